sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Upstream feeder for the sobel gradient stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle.
- Buffers the two previous image rows and presents a 3x3 neighbourhood as the eight 9-bit operands p0..p8 the sobel stage consumes. The centre pixel p4 is not output.
- Asserts win_valid only for windows lying entirely inside the image.

Parameters:
- IMG_W, 64, image width in pixels; minimum 3. Sets the line-buffer depth.
- PIX_W, 8, input pixel width. Outputs are PIX_W+1 bits, zero-extended.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pix_in  input  PIX_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in is accepted on this edge. There is no backpressure.
- sof  input  1  start of frame; qualified by pix_valid. The accepted pixel becomes (row 0, col 0).
- p0,p1,p2  output  PIX_W+1  window top row, row y-2: columns x-2, x-1, x.
- p3,p5  output  PIX_W+1  window middle row, row y-1: columns x-2 and x.
- p6,p7,p8  output  PIX_W+1  window bottom row, row y: columns x-2, x-1, x. p8 is the newest pixel.
- win_valid  output  1  p0..p8 form a complete in-image window.

Behaviour:
- Reset (rst_n=0 at an edge):
  - col, row, win_valid and all window registers cleared to 0.
  - Line-buffer RAM contents are not cleared; the row gating makes them don't-care.
  - Reset mid-frame discards the frame. The next accepted pixel is treated as (0,0) whether or not sof is asserted.
- Storage:
  - Two line buffers, LB1 (row y-1) and LB2 (row y-2), each IMG_W x PIX_W, indexed by col.
  - Read and write happen at the same index on the same accepted edge (read-before-write).
  - LB1[col] <= pix_in; LB2[col] <= old LB1[col].
- Window shift, on each accepted pixel only:
  - Top row: p0<=p1, p1<=p2, p2<=old LB2[col].
  - Middle row: p3<=mid_c (internal x-1 register), mid_c<=p5, p5<=old LB1[col].
  - Bottom row: p6<=p7, p7<=p8, p8<=pix_in.
  - All outputs are zero-extended ({1'b0,pixel}).
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0, incrementing row.
  - row saturates at 2; only row>=2 matters.
  - pix_valid with sof forces the accepted pixel to (0,0). col becomes 1 and row 0 after that edge.
- win_valid:
  - Registered. It goes 1 on the edge that accepts a pixel whose pre-update position satisfies row>=2 and col>=2; otherwise it goes 0.
  - It is a one-cycle pulse per qualifying pixel.
  - Latency is one cycle: the window containing pixel (y,x) is valid in the cycle after that pixel is accepted.
- Idle cycles (pix_valid=0):
  - No state changes, except win_valid, which drops to 0.
  - Window registers hold their values.
- Borders:
  - Columns 0 and 1 of each row produce no valid window; the window there would wrap across lines.
  - Rows 0 and 1 of a frame produce no valid window.
  - An IMG_W x H frame yields exactly (IMG_W-2)*(H-2) valid pulses.
- sof mid-frame: the counters restart immediately; the partial frame's remaining windows are never emitted.
- No end-of-frame handling: the last accepted pixel produces its window, then the block idles.

Test Plan:
- Baseline window (IMG_W=8, continuous valid, sof on the first pixel, pixel = row*16+col): after pixel 0x22 is accepted, the next cycle shows win_valid=1 with p0=0x000, p1=0x001, p2=0x002, p3=0x010, p5=0x012, p6=0x020, p7=0x021, p8=0x022.
- Pulse count (same 8x8 frame): exactly 36 win_valid pulses. None while accepting pixels with row<2 or col<2; in particular none after 0x30 or 0x31.
- Gaps in pix_valid (same frame, one idle cycle after every pixel): identical window sequence and count of 36. win_valid is never high on two consecutive cycles, and outputs hold during the gaps.
- sof mid-frame (sof asserted at pixel (4,5), then a fresh frame): no win_valid until pixel (2,2) of the new frame. The first new window matches the baseline values.
- Reset mid-frame (rst_n=0 for one edge after pixel (3,4)): win_valid=0 and p0..p8=0 the next cycle. The following pixels restart at (0,0) without sof, and the first valid window again follows pixel 0x22.
- Saturation and full values (all pixels 0xFF): every output is 0x0FF, bit 8 is never set, and the pulse count is unchanged.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Pixel-stream in / 3x3 window out bundle between a raster source and the sobel stage.
interface sobel_window_gen_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             sof;
  logic [PIX_W:0]   p0, p1, p2, p3, p5, p6, p7, p8;
  logic             win_valid;

  modport master (
    output pix_in, pix_valid, sof,
    input  p0, p1, p2, p3, p5, p6, p7, p8, win_valid
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p0, p1, p2, p3, p5, p6, p7, p8, win_valid
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Two line buffers plus a 3x3 shift window; emits the eight sobel operands for
// every pixel whose full neighbourhood lies inside the image.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_window_gen_if.slave  win_if
);
  localparam int CW = $clog2(IMG_W);

  logic [CW-1:0]    col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             wv_q, wv_d;
  logic [PIX_W-1:0] p0_q, p1_q, p2_q, p3_q, midc_q, p5_q, p6_q, p7_q, p8_q;
  logic [PIX_W-1:0] p0_d, p1_d, p2_d, p3_d, midc_d, p5_d, p6_d, p7_d, p8_d;

  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];

  logic [CW-1:0]    pos_col;
  logic [1:0]       pos_row;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;

  // sof relocates the accepted pixel to (0,0) before anything else uses the position
  always_comb begin
    pos_col = win_if.sof ? '0 : col_q;
    pos_row = win_if.sof ? 2'd0 : row_q;
    lb1_rd  = lb1_q[pos_col];
    lb2_rd  = lb2_q[pos_col];
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    wv_d   = 1'b0;
    p0_d   = p0_q;
    p1_d   = p1_q;
    p2_d   = p2_q;
    p3_d   = p3_q;
    midc_d = midc_q;
    p5_d   = p5_q;
    p6_d   = p6_q;
    p7_d   = p7_q;
    p8_d   = p8_q;
    if (win_if.pix_valid) begin
      p0_d   = p1_q;
      p1_d   = p2_q;
      p2_d   = lb2_rd;
      p3_d   = midc_q;
      midc_d = p5_q;
      p5_d   = lb1_rd;
      p6_d   = p7_q;
      p7_d   = p8_q;
      p8_d   = win_if.pix_in;
      wv_d   = (pos_row == 2'd2) && (pos_col >= CW'(2));
      row_d  = pos_row;
      if (pos_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (pos_row != 2'd2) row_d = pos_row + 2'd1;
      end else begin
        col_d = pos_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      wv_q   <= 1'b0;
      p0_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      p3_q   <= '0;
      midc_q <= '0;
      p5_q   <= '0;
      p6_q   <= '0;
      p7_q   <= '0;
      p8_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wv_q   <= wv_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      p3_q   <= p3_d;
      midc_q <= midc_d;
      p5_q   <= p5_d;
      p6_q   <= p6_d;
      p7_q   <= p7_d;
      p8_q   <= p8_d;
    end
  end

  // Line RAMs carry no reset; rows 0/1 gating hides stale contents
  always_ff @(posedge clk) begin
    if (rst_n && win_if.pix_valid) begin
      lb1_q[pos_col] <= win_if.pix_in;
      lb2_q[pos_col] <= lb1_rd;
    end
  end

  assign win_if.p0        = {1'b0, p0_q};
  assign win_if.p1        = {1'b0, p1_q};
  assign win_if.p2        = {1'b0, p2_q};
  assign win_if.p3        = {1'b0, p3_q};
  assign win_if.p5        = {1'b0, p5_q};
  assign win_if.p6        = {1'b0, p6_q};
  assign win_if.p7        = {1'b0, p7_q};
  assign win_if.p8        = {1'b0, p8_q};
  assign win_if.win_valid = wv_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: frame-image reference model with per-cycle compare.
module tb_sobel_window_gen;
  localparam int W  = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW)) wif ();
  sobel_window_gen #(.IMG_W(W), .PIX_W(PW)) dut (.clk(clk), .rst_n(rst_n), .win_if(wif));

  int total = 0;
  int bad = 0;
  int pulses = 0;

  int         mrow, mcol;
  logic [7:0] img [0:15][0:W-1];
  logic [7:0] hist [$];
  bit         armed = 0, exp_wv = 0, chk_zero = 0, chk_hold = 0;
  logic [8:0] exp_p [9];
  logic [8:0] prev_p [9];

  function automatic logic [8:0] dutp(int k);
    case (k)
      0: return wif.p0;
      1: return wif.p1;
      2: return wif.p2;
      3: return wif.p3;
      5: return wif.p5;
      6: return wif.p6;
      7: return wif.p7;
      default: return wif.p8;
    endcase
  endfunction

  task automatic chk(string name, logic [8:0] act, logic [8:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: the frame is kept as a 2-D image; a window is just a lookup into it
  task automatic model_update(bit v, bit s, logic [7:0] p, bit r);
    armed = 1;
    if (!r) begin
      mrow = 0; mcol = 0;
      hist = {8'h00, 8'h00, 8'h00};
      exp_wv = 0; chk_zero = 1; chk_hold = 0;
    end else if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      if (mrow < 16) img[mrow][mcol] = p;
      exp_wv = (mrow >= 2) && (mrow < 16) && (mcol >= 2);
      if (exp_wv) begin
        exp_p[0] = {1'b0, img[mrow-2][mcol-2]};
        exp_p[1] = {1'b0, img[mrow-2][mcol-1]};
        exp_p[2] = {1'b0, img[mrow-2][mcol]};
        exp_p[3] = {1'b0, img[mrow-1][mcol-2]};
        exp_p[5] = {1'b0, img[mrow-1][mcol]};
        exp_p[6] = {1'b0, img[mrow][mcol-2]};
        exp_p[7] = {1'b0, img[mrow][mcol-1]};
        exp_p[8] = {1'b0, img[mrow][mcol]};
      end
      hist.push_back(p);
      void'(hist.pop_front());
      mcol++;
      if (mcol == W) begin mcol = 0; mrow++; end
      chk_zero = 0; chk_hold = 0;
    end else begin
      exp_wv = 0; chk_hold = 1; chk_zero = 0;
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("win_valid", {8'h00, wif.win_valid}, {8'h00, exp_wv});
      if (wif.win_valid === 1'b1) pulses++;
      if (exp_wv) begin
        for (int k = 0; k < 6; k++)
          if (k != 4) chk($sformatf("p%0d", k), dutp(k), exp_p[k]);
      end
      chk("p6_hist", wif.p6, {1'b0, hist[0]});
      chk("p7_hist", wif.p7, {1'b0, hist[1]});
      chk("p8_hist", wif.p8, {1'b0, hist[2]});
      if (chk_zero) begin
        for (int k = 0; k < 6; k++)
          if (k != 4) chk($sformatf("p%0d_zero", k), dutp(k), 9'h000);
      end
      if (chk_hold) begin
        for (int k = 0; k < 9; k++)
          if (k != 4) chk($sformatf("p%0d_hold", k), dutp(k), prev_p[k]);
      end
      for (int k = 0; k < 9; k++)
        if (k != 4) prev_p[k] = dutp(k);
    end
  end

  task automatic step(bit v, bit s, logic [7:0] p, bit r);
    @(negedge clk);
    #1;
    wif.pix_valid = v;
    wif.sof       = s;
    wif.pix_in    = p;
    rst_n         = r;
    @(posedge clk);
    #1;
    model_update(v, s, p, r);
  endtask

  task automatic check_base();
    chk("base_wv", {8'h00, wif.win_valid}, 9'h001);
    chk("base_p0", wif.p0, 9'h000);
    chk("base_p1", wif.p1, 9'h001);
    chk("base_p2", wif.p2, 9'h002);
    chk("base_p3", wif.p3, 9'h010);
    chk("base_p5", wif.p5, 9'h012);
    chk("base_p6", wif.p6, 9'h020);
    chk("base_p7", wif.p7, 9'h021);
    chk("base_p8", wif.p8, 9'h022);
  endtask

  // mode: 0 row*16+col, 1 all 0xFF, 2 random; gap: 0 none, 1 one idle, 2 random 0..2
  task automatic send_frame(int h, int mode, int gap, bit sof_first, int stop_r, int stop_c);
    logic [7:0] pix;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == stop_r && x == stop_c) return;
        case (mode)
          0: pix = 8'((y << 4) | x);
          1: pix = 8'hFF;
          default: pix = 8'($urandom_range(0, 255));
        endcase
        step(1'b1, sof_first && y == 0 && x == 0, pix, 1'b1);
        if (mode == 0 && y == 2 && x == 2) check_base();
        if (gap == 1) step(1'b0, 1'b0, 8'($urandom), 1'b1);
        else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'($urandom), 1'b1);
      end
    end
  endtask

  task automatic idle2_reset_count();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    pulses = 0;
  endtask

  task automatic idle2_check(string name, int expn);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk(name, 9'(pulses), 9'(expn));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    wif.pix_valid = 1'b0;
    wif.sof       = 1'b0;
    wif.pix_in    = '0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    idle2_reset_count();
    send_frame(8, 0, 0, 1'b1, -1, -1);
    idle2_check("pulses_base", 36);

    idle2_reset_count();
    send_frame(8, 0, 1, 1'b1, -1, -1);
    idle2_check("pulses_gap", 36);

    idle2_reset_count();
    send_frame(6, 2, 2, 1'b1, -1, -1);
    idle2_check("pulses_rand", 24);

    // partial frame up to (4,4), then sof on what would have been (4,5)
    idle2_reset_count();
    send_frame(8, 0, 0, 1'b1, 4, 5);
    send_frame(8, 0, 0, 1'b1, -1, -1);
    idle2_check("pulses_sof_mid", 15 + 36);

    // reset after (3,4); next frame carries no sof
    idle2_reset_count();
    send_frame(8, 0, 0, 1'b1, 3, 5);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(8, 0, 0, 1'b0, -1, -1);
    idle2_check("pulses_rst_mid", 9 + 36);

    idle2_reset_count();
    send_frame(8, 1, 2, 1'b1, -1, -1);
    idle2_check("pulses_ff", 36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
